wb_queue: RTL and testbench

- Writeback buffer directly upstream of the 8-entry register file. It merges results from the ALU path and the load path into the register file's single write port.
- Pending writes are held in a small in-order FIFO, one write is issued per cycle, and the block drives the register file's wr_en, wr_addr and dat_in.
- It also exports a per-register pending mask and a forwarding lookup, so decode can detect and resolve read-after-write hazards on not-yet-written registers.

---
 rtl/wb_queue_if.sv | 44 ++++
 rtl/wb_queue.sv | 150 +++++++++++++++
 tb/tb_wb_queue.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_queue_if.sv
// Writeback queue bus: ALU and load result producers, register file
// write port, forwarding lookup and status.
//   master : result producers / decode (drive results, fwd_addr)
//   slave  : wb_queue (drives wr_*, in_ready, pend, fwd_*, ovf, count)
interface wb_queue_if #(
   parameter int pw    = 3,
   parameter int dw    = 8,
   parameter int depth = 4
);
   localparam int cw = $clog2(depth) + 1;

   logic              alu_valid;
   logic [pw-1:0]     alu_addr;
   logic [dw-1:0]     alu_data;
   logic              ld_valid;
   logic [pw-1:0]     ld_addr;
   logic [dw-1:0]     ld_data;
   logic              in_ready;
   logic              wr_en;
   logic [pw-1:0]     wr_addr;
   logic [dw-1:0]     wr_data;
   logic [pw-1:0]     fwd_addr;
   logic              fwd_hit;
   logic [dw-1:0]     fwd_data;
   logic [2**pw-1:0]  pend;
   logic              ovf;
   logic [cw-1:0]     count;

   modport master (
      output alu_valid, alu_addr, alu_data,
      output ld_valid, ld_addr, ld_data,
      output fwd_addr,
      input  in_ready, wr_en, wr_addr, wr_data,
      input  fwd_hit, fwd_data, pend, ovf, count
   );

   modport slave (
      input  alu_valid, alu_addr, alu_data,
      input  ld_valid, ld_addr, ld_data,
      input  fwd_addr,
      output in_ready, wr_en, wr_addr, wr_data,
      output fwd_hit, fwd_data, pend, ovf, count
   );
endinterface

// File: rtl/wb_queue.sv
// Writeback buffer: merges ALU and load results into one in-order
// register file write stream, with pending mask and forwarding lookup.
//   clk, reset : clock, synchronous active-high reset
//   bus        : wb_queue_if slave (results in, wr_* out, fwd/pend/status)
module wb_queue #(
   parameter int pw    = 3,
   parameter int dw    = 8,
   parameter int depth = 4
) (
   input  logic     clk,
   input  logic     reset,
   wb_queue_if.slave bus
);
   localparam int aw = $clog2(depth);
   localparam int cw = aw + 1;

   logic [pw-1:0]    r_faddr [depth];
   logic [dw-1:0]    r_fdata [depth];
   logic [aw-1:0]    r_rd;
   logic [aw-1:0]    r_wr;
   logic [cw-1:0]    r_count;
   logic             r_wr_en;
   logic [pw-1:0]    r_wr_addr;
   logic [dw-1:0]    r_wr_data;
   logic             r_ovf;

   logic [cw-1:0]    w_space;
   logic             w_ready;
   logic             w_a;
   logic             w_l;
   logic             w_pop;
   logic [1:0]       w_n_push;
   logic [pw-1:0]    w_p0_addr;
   logic [dw-1:0]    w_p0_data;
   logic [aw-1:0]    w_wr1;
   logic [aw-1:0]    w_idx;
   logic [2**pw-1:0] w_pend;
   logic             w_hit;
   logic [dw-1:0]    w_fdat;

   assign w_space = cw'(depth) - r_count;
   assign w_ready = w_space >= cw'(2);
   assign w_a     = bus.alu_valid & w_ready;
   assign w_l     = bus.ld_valid & w_ready;
   assign w_pop   = r_count != '0;
   assign w_wr1   = r_wr + aw'(1);

   // When the FIFO is non-empty every accepted result is pushed;
   // otherwise the first accepted result bypasses to the output reg.
   // The second push slot is only ever the load result.
   always_comb begin
      w_n_push  = 2'd0;
      w_p0_addr = bus.alu_addr;
      w_p0_data = bus.alu_data;
      if (w_pop) begin
         w_n_push = {1'b0, w_a} + {1'b0, w_l};
         if (!w_a) begin
            w_p0_addr = bus.ld_addr;
            w_p0_data = bus.ld_data;
         end
      end else if (w_a && w_l) begin
         w_n_push  = 2'd1;
         w_p0_addr = bus.ld_addr;
         w_p0_data = bus.ld_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd      <= '0;
         r_wr      <= '0;
         r_count   <= '0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_ovf     <= 1'b0;
      end else begin
         if (w_pop) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_faddr[r_rd];
            r_wr_data <= r_fdata[r_rd];
            r_rd      <= r_rd + aw'(1);
         end else if (w_a) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= bus.alu_addr;
            r_wr_data <= bus.alu_data;
         end else if (w_l) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= bus.ld_addr;
            r_wr_data <= bus.ld_data;
         end else begin
            r_wr_en   <= 1'b0;
         end
         r_wr    <= r_wr + aw'(w_n_push);
         r_count <= r_count + cw'(w_n_push)
                    - cw'(w_pop);
         if ((bus.alu_valid || bus.ld_valid) && !w_ready)
            r_ovf <= 1'b1;
      end
   end

   // Entry storage needs no reset; validity comes from r_count.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (w_n_push != 2'd0) begin
            r_faddr[r_wr] <= w_p0_addr;
            r_fdata[r_wr] <= w_p0_data;
         end
         if (w_n_push == 2'd2) begin
            r_faddr[w_wr1] <= bus.ld_addr;
            r_fdata[w_wr1] <= bus.ld_data;
         end
      end
   end

   // Scan oldest to youngest so the last match wins.
   always_comb begin
      w_pend = '0;
      w_hit  = 1'b0;
      w_fdat = '0;
      w_idx  = r_rd;
      if (r_wr_en) begin
         w_pend[r_wr_addr] = 1'b1;
         if (r_wr_addr == bus.fwd_addr) begin
            w_hit  = 1'b1;
            w_fdat = r_wr_data;
         end
      end
      for (int k = 0; k < depth; k++) begin
         w_idx = r_rd + aw'(k);
         if (cw'(k) < r_count) begin
            w_pend[r_faddr[w_idx]] = 1'b1;
            if (r_faddr[w_idx] == bus.fwd_addr) begin
               w_hit  = 1'b1;
               w_fdat = r_fdata[w_idx];
            end
         end
      end
   end

   assign bus.in_ready = w_ready;
   assign bus.wr_en    = r_wr_en;
   assign bus.wr_addr  = r_wr_addr;
   assign bus.wr_data  = r_wr_data;
   assign bus.fwd_hit  = w_hit;
   assign bus.fwd_data = w_fdat;
   assign bus.pend     = w_pend;
   assign bus.ovf      = r_ovf;
   assign bus.count    = r_count;
endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: directed vector table, fill/overflow
// and reset-mid-burst sequences, and random traffic against a queue model.
module tb_wb_queue;
   localparam int PW    = 3;
   localparam int DW    = 8;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   wb_queue_if #(.pw(PW), .dw(DW), .depth(DEPTH)) bus ();

   wb_queue #(.pw(PW), .dw(DW), .depth(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [PW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   typedef struct {
      bit            rst;
      bit            av;
      logic [PW-1:0] aa;
      logic [DW-1:0] ad;
      bit            lv;
      logic [PW-1:0] la;
      logic [DW-1:0] ld;
      logic [PW-1:0] fa;
      bit            en;
      logic [PW-1:0] wa;
      logic [DW-1:0] wd;
      int            cnt;
      logic [7:0]    pend;
      bit            hit;
      logic [DW-1:0] fd;
   } vec_t;

   wr_t           mq[$];
   logic          m_en;
   logic [PW-1:0] m_addr;
   logic [DW-1:0] m_data;
   logic          m_ovf;
   int            checks = 0;
   int            errors = 0;
   bit            cap = 0;
   logic [DW-1:0] seen[$];
   vec_t          tbl[14];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t",
                  name, act, exp, $time);
      end
   endtask

   // Model: all pending writes as one ordered list; each edge the
   // oldest one (if any) becomes the register file write.
   task automatic model_step(bit rst, bit av, logic [PW-1:0] aa,
                             logic [DW-1:0] ad, bit lv,
                             logic [PW-1:0] la, logic [DW-1:0] ld);
      wr_t all[$];
      wr_t w;
      bit  rdy;
      if (rst) begin
         mq.delete();
         m_en = 0; m_addr = 0; m_data = 0; m_ovf = 0;
         return;
      end
      rdy = (DEPTH - mq.size()) >= 2;
      all = mq;
      if (rdy) begin
         if (av) all.push_back(wr_t'{a: aa, d: ad});
         if (lv) all.push_back(wr_t'{a: la, d: ld});
      end else if (av || lv) begin
         m_ovf = 1;
      end
      if (all.size() > 0) begin
         w = all.pop_front();
         m_en = 1; m_addr = w.a; m_data = w.d;
      end else begin
         m_en = 0;
      end
      mq = all;
   endtask

   task automatic model_check();
      logic [7:0]    p;
      logic          h;
      logic [DW-1:0] fd;
      p = 0; h = 0; fd = 0;
      if (m_en) begin
         p[m_addr] = 1;
         if (m_addr == bus.fwd_addr) begin h = 1; fd = m_data; end
      end
      foreach (mq[i]) begin
         p[mq[i].a] = 1;
         if (mq[i].a == bus.fwd_addr) begin h = 1; fd = mq[i].d; end
      end
      chk("wr_en", bus.wr_en, m_en);
      chk("wr_addr", bus.wr_addr, m_addr);
      chk("wr_data", bus.wr_data, m_data);
      chk("count", bus.count, mq.size());
      chk("in_ready", bus.in_ready, (DEPTH - mq.size()) >= 2);
      chk("pend", bus.pend, p);
      chk("fwd_hit", bus.fwd_hit, h);
      chk("fwd_data", bus.fwd_data, fd);
      chk("ovf", bus.ovf, m_ovf);
   endtask

   task automatic cycle(bit rst, bit av, logic [PW-1:0] aa,
                        logic [DW-1:0] ad, bit lv, logic [PW-1:0] la,
                        logic [DW-1:0] ld, logic [PW-1:0] fa);
      reset         = rst;
      bus.alu_valid = av;
      bus.alu_addr  = aa;
      bus.alu_data  = ad;
      bus.ld_valid  = lv;
      bus.ld_addr   = la;
      bus.ld_data   = ld;
      bus.fwd_addr  = fa;
      @(posedge clk);
      model_step(rst, av, aa, ad, lv, la, ld);
      #1;
      model_check();
      if (cap && bus.wr_en) seen.push_back(bus.wr_data);
   endtask

   task automatic idle(logic [PW-1:0] fa);
      cycle(0, 0, 0, 0, 0, 0, 0, fa);
   endtask

   initial begin
      int n;
      int prob;
      logic [DW-1:0] exp_fill[6];

      tbl[0]  = '{1,0,0,0,    0,0,0,    0, 0,0,0,    0,8'h00,0,0};
      tbl[1]  = '{0,0,0,0,    0,0,0,    0, 0,0,0,    0,8'h00,0,0};
      tbl[2]  = '{0,0,0,0,    0,0,0,    0, 0,0,0,    0,8'h00,0,0};
      tbl[3]  = '{0,0,0,0,    0,0,0,    0, 0,0,0,    0,8'h00,0,0};
      tbl[4]  = '{0,0,0,0,    0,0,0,    0, 0,0,0,    0,8'h00,0,0};
      tbl[5]  = '{0,0,0,0,    0,0,0,    0, 0,0,0,    0,8'h00,0,0};
      tbl[6]  = '{0,1,3,8'h5A,0,0,0,    3, 1,3,8'h5A,0,8'h08,1,8'h5A};
      tbl[7]  = '{0,0,0,0,    0,0,0,    3, 0,3,8'h5A,0,8'h00,0,0};
      tbl[8]  = '{0,1,1,8'h11,1,2,8'h22,2, 1,1,8'h11,1,8'h06,1,8'h22};
      tbl[9]  = '{0,0,0,0,    0,0,0,    2, 1,2,8'h22,0,8'h04,1,8'h22};
      tbl[10] = '{0,0,0,0,    0,0,0,    5, 0,2,8'h22,0,8'h00,0,0};
      tbl[11] = '{0,1,5,8'hAA,0,0,0,    5, 1,5,8'hAA,0,8'h20,1,8'hAA};
      tbl[12] = '{0,0,0,0,    1,5,8'hBB,5, 1,5,8'hBB,0,8'h20,1,8'hBB};
      tbl[13] = '{0,0,0,0,    0,0,0,    5, 0,5,8'hBB,0,8'h00,0,0};

      for (int i = 0; i < 14; i++) begin
         cycle(tbl[i].rst, tbl[i].av, tbl[i].aa, tbl[i].ad,
               tbl[i].lv, tbl[i].la, tbl[i].ld, tbl[i].fa);
         chk($sformatf("v%0d_wr_en", i), bus.wr_en, tbl[i].en);
         chk($sformatf("v%0d_wr_addr", i), bus.wr_addr, tbl[i].wa);
         chk($sformatf("v%0d_wr_data", i), bus.wr_data, tbl[i].wd);
         chk($sformatf("v%0d_count", i), bus.count, tbl[i].cnt);
         chk($sformatf("v%0d_pend", i), bus.pend, tbl[i].pend);
         chk($sformatf("v%0d_hit", i), bus.fwd_hit, tbl[i].hit);
         chk($sformatf("v%0d_fdata", i), bus.fwd_data, tbl[i].fd);
         chk($sformatf("v%0d_ready", i), bus.in_ready, 1);
         chk($sformatf("v%0d_ovf", i), bus.ovf, 0);
      end

      // Fill and overflow
      cycle(1, 0, 0, 0, 0, 0, 0, 0);
      cap = 1;
      seen.delete();
      for (int i = 0; i < 4; i++) begin
         cycle(0, 1, 3'(i), 8'hA0 + 8'(i), 1, 3'(i + 4),
               8'hB0 + 8'(i), 0);
         if (i == 1) chk("fill_ready_hi", bus.in_ready, 1);
         if (i == 2) begin
            chk("fill_count3", bus.count, 3);
            chk("fill_ready_lo", bus.in_ready, 0);
            chk("fill_ovf_clr", bus.ovf, 0);
         end
      end
      chk("ovf_set", bus.ovf, 1);
      n = 0;
      while ((bus.wr_en || bus.count != 0) && n < 20) begin
         idle(0);
         n++;
      end
      chk("drain_timeout", n < 20, 1);
      chk("ovf_sticky", bus.ovf, 1);
      exp_fill = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2};
      chk("fill_writes", seen.size(), 6);
      for (int i = 0; i < 6; i++)
         if (i < seen.size())
            chk($sformatf("fill_order%0d", i), seen[i], exp_fill[i]);
      cap = 0;

      // Reset mid-burst
      cycle(1, 0, 0, 0, 0, 0, 0, 0);
      cap = 1;
      seen.delete();
      for (int i = 0; i < 3; i++)
         cycle(0, 1, 3'(i), 8'hC0 + 8'(i), 1, 3'(i + 4),
               8'hD0 + 8'(i), 0);
      chk("burst_count3", bus.count, 3);
      cycle(1, 1, 1, 8'hEE, 1, 2, 8'hEF, 0);
      chk("rst_count", bus.count, 0);
      chk("rst_wr_en", bus.wr_en, 0);
      chk("rst_pend", bus.pend, 0);
      chk("rst_ovf", bus.ovf, 0);
      for (int i = 0; i < 4; i++) idle(0);
      chk("rst_discard", seen.size(), 3);
      cap = 0;

      // Random traffic
      prob = 50;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) prob = $urandom_range(20, 95);
         cycle($urandom_range(0, 99) == 0,
               $urandom_range(0, 99) < prob, 3'($urandom),
               8'($urandom),
               $urandom_range(0, 99) < prob, 3'($urandom),
               8'($urandom), 3'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
